// File: rtl/bram_loader_pkg.sv
// Shared definitions for the BRAM program loader: FSM state encoding and
// default start / halt addresses. The optional run counter is enabled with
// the BRAM_LOADER_CYCLE_COUNT_EN macro (see bram_loader_halt_monitor).
package bram_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_FLUSH = 3'd2,
        ST_START = 3'd3,
        ST_RUN   = 3'd4,
        ST_DONE  = 3'd5
    } loader_state_t;

    localparam logic [31:0] DEFAULT_PROGRAM_ADDRESS = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_HALT_PC         = 32'h0000_00A8;
    localparam int          CYCLE_COUNT_W           = 32;

endpackage

// File: rtl/bram_loader_halt_monitor.sv
// Halt / timeout watcher for the loaded core. Compares PC against the halt
// address and the address one instruction later. With BRAM_LOADER_CYCLE_COUNT_EN
// defined it also keeps a saturating run counter and raises a timeout at
// MAX_CYCLES; without it the count is tied to 0 and timeout never fires.
module bram_loader_halt_monitor
    import bram_loader_pkg::*;
#(
    parameter int                      ADDRESS_BITS = 32,
    parameter logic [ADDRESS_BITS-1:0] HALT_PC      = ADDRESS_BITS'(DEFAULT_HALT_PC),
    parameter int unsigned             MAX_CYCLES   = 1000000
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_clear,   // zero the counter (cycle before START)
    input  logic                     i_enable,  // count this cycle (START and RUN)
    input  logic                     i_check,   // halt / timeout evaluated (RUN only)
    input  logic [ADDRESS_BITS-1:0]  i_pc,
    output logic                     o_halt,
    output logic                     o_timeout,
    output logic [CYCLE_COUNT_W-1:0] o_count
);

    localparam logic [ADDRESS_BITS-1:0] HALT_PC_NEXT = HALT_PC + ADDRESS_BITS'(4);

    assign o_halt = i_check && ((i_pc == HALT_PC) || (i_pc == HALT_PC_NEXT));

`ifdef BRAM_LOADER_CYCLE_COUNT_EN
    logic [CYCLE_COUNT_W-1:0] r_count;

    // Run-length counter: cleared before START, saturates at all ones.
    always_ff @(posedge i_clock) begin
        if (i_reset || i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != '1)) begin
            r_count <= r_count + CYCLE_COUNT_W'(1);
        end
    end

    assign o_count   = r_count;
    assign o_timeout = i_check && (r_count >= CYCLE_COUNT_W'(MAX_CYCLES));
`else
    logic w_unused;
    assign w_unused  = ^{i_clock, i_reset, i_clear, i_enable};
    assign o_count   = '0;
    assign o_timeout = 1'b0;
`endif

endmodule

// File: rtl/bram_program_loader.sv
// Program loader for single-cycle BRAM cores: streams words into the BRAM
// write port with the core in reset, releases the core with a one-cycle
// start pulse, then waits for a halt PC (or, with BRAM_LOADER_CYCLE_COUNT_EN
// defined, a MAX_CYCLES timeout) and reports done/error/cycle_count.
module bram_program_loader
    import bram_loader_pkg::*;
#(
    parameter int                      DATA_WIDTH       = 32,
    parameter int                      ADDRESS_BITS     = 32,
    parameter int                      MEM_ADDRESS_BITS = 14,
    parameter logic [ADDRESS_BITS-1:0] PROGRAM_ADDRESS  = ADDRESS_BITS'(DEFAULT_PROGRAM_ADDRESS),
    parameter logic [ADDRESS_BITS-1:0] HALT_PC          = ADDRESS_BITS'(DEFAULT_HALT_PC),
    parameter int unsigned             MAX_CYCLES       = 1000000
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    input  logic                        i_load_begin,
    input  logic                        i_load_valid,
    output logic                        o_load_ready,
    input  logic [DATA_WIDTH-1:0]       i_load_data,
    input  logic                        i_load_last,
    output logic                        o_mem_we,
    output logic [DATA_WIDTH/8-1:0]     o_mem_byte_en,
    output logic [MEM_ADDRESS_BITS-1:0] o_mem_address,
    output logic [DATA_WIDTH-1:0]       o_mem_data,
    output logic                        o_core_reset,
    output logic                        o_start,
    output logic [ADDRESS_BITS-1:0]     o_program_address,
    input  logic [ADDRESS_BITS-1:0]     i_pc,
    output logic                        o_busy,
    output logic                        o_done,
    output logic                        o_error,
    output logic [CYCLE_COUNT_W-1:0]    o_cycle_count
);

    localparam logic [MEM_ADDRESS_BITS-1:0] PTR_MAX = '1;

    loader_state_t               r_state;
    logic [MEM_ADDRESS_BITS-1:0] r_ptr;
    logic                        r_load_ready;
    logic                        r_mem_we;
    logic [DATA_WIDTH/8-1:0]     r_mem_byte_en;
    logic [MEM_ADDRESS_BITS-1:0] r_mem_address;
    logic [DATA_WIDTH-1:0]       r_mem_data;
    logic                        r_core_reset;
    logic                        r_start;
    logic [ADDRESS_BITS-1:0]     r_program_address;
    logic                        r_busy;
    logic                        r_done;
    logic                        r_error;
    logic [CYCLE_COUNT_W-1:0]    r_cycle_count;

    logic                        w_accept;
    logic                        w_halt;
    logic                        w_timeout;
    logic [CYCLE_COUNT_W-1:0]    w_count;

    // load_ready is only ever high in LOAD, so this is the LOAD handshake.
    assign w_accept = i_load_valid && r_load_ready;

    bram_loader_halt_monitor #(
        .ADDRESS_BITS (ADDRESS_BITS),
        .HALT_PC      (HALT_PC),
        .MAX_CYCLES   (MAX_CYCLES)
    ) u_halt_monitor (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .i_clear   (r_state == ST_FLUSH),
        .i_enable  ((r_state == ST_START) || (r_state == ST_RUN)),
        .i_check   (r_state == ST_RUN),
        .i_pc      (i_pc),
        .o_halt    (w_halt),
        .o_timeout (w_timeout),
        .o_count   (w_count)
    );

    // Loader FSM with all outputs registered; writes land one cycle after acceptance.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state           <= ST_IDLE;
            r_ptr             <= '0;
            r_load_ready      <= 1'b0;
            r_mem_we          <= 1'b0;
            r_mem_byte_en     <= '0;
            r_mem_address     <= '0;
            r_mem_data        <= '0;
            r_core_reset      <= 1'b1;
            r_start           <= 1'b0;
            r_program_address <= '0;
            r_busy            <= 1'b0;
            r_done            <= 1'b0;
            r_error           <= 1'b0;
            r_cycle_count     <= '0;
        end else begin
            r_mem_we      <= 1'b0;
            r_mem_byte_en <= '0;
            r_start       <= 1'b0;

            if (w_accept) begin
                r_mem_we      <= 1'b1;
                r_mem_byte_en <= '1;
                r_mem_address <= r_ptr;
                r_mem_data    <= i_load_data;
                // Pointer never wraps: the word at PTR_MAX either ends the
                // program or takes the overflow exit below.
                if (r_ptr != PTR_MAX) r_ptr <= r_ptr + MEM_ADDRESS_BITS'(1);
            end

            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (i_load_begin) begin
                        r_state           <= ST_LOAD;
                        r_ptr             <= '0;
                        r_load_ready      <= 1'b1;
                        r_busy            <= 1'b1;
                        r_done            <= 1'b0;
                        r_error           <= 1'b0;
                        r_core_reset      <= 1'b1;
                        r_program_address <= '0;
                        r_cycle_count     <= '0;
                    end
                end
                ST_LOAD: begin
                    if (w_accept) begin
                        if (i_load_last) begin
                            r_state      <= ST_FLUSH;
                            r_load_ready <= 1'b0;
                        end else if (r_ptr == PTR_MAX) begin
                            // Program does not fit: finish the write, never start the core.
                            r_state      <= ST_DONE;
                            r_load_ready <= 1'b0;
                            r_busy       <= 1'b0;
                            r_error      <= 1'b1;
                        end
                    end
                end
                ST_FLUSH: begin
                    r_state           <= ST_START;
                    r_core_reset      <= 1'b0;
                    r_start           <= 1'b1;
                    r_program_address <= PROGRAM_ADDRESS;
                end
                ST_START: begin
                    r_state <= ST_RUN;
                end
                ST_RUN: begin
                    // Halt wins if it coincides with the timeout.
                    if (w_halt) begin
                        r_state       <= ST_DONE;
                        r_busy        <= 1'b0;
                        r_done        <= 1'b1;
                        r_cycle_count <= w_count;
                    end else if (w_timeout) begin
                        r_state       <= ST_DONE;
                        r_busy        <= 1'b0;
                        r_error       <= 1'b1;
                        r_cycle_count <= w_count;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_load_ready      = r_load_ready;
    assign o_mem_we          = r_mem_we;
    assign o_mem_byte_en     = r_mem_byte_en;
    assign o_mem_address     = r_mem_address;
    assign o_mem_data        = r_mem_data;
    assign o_core_reset      = r_core_reset;
    assign o_start           = r_start;
    assign o_program_address = r_program_address;
    assign o_busy            = r_busy;
    assign o_done            = r_done;
    assign o_error           = r_error;
    assign o_cycle_count     = r_cycle_count;

endmodule

// File: tb/tb_bram_program_loader.sv
// Scoreboard bench for bram_program_loader: stimulus pushes expected BRAM
// writes, start pulses and run results (with their cycle numbers) into a
// queue; a negedge monitor pops and compares whenever the DUT shows one.
module tb_bram_program_loader;

    localparam int          MEMB   = 2;
    localparam int          DEPTH  = 1 << MEMB;
    localparam int          MAXC   = 50;
    localparam logic [31:0] PADDR  = 32'h0000_0080;
`ifdef BRAM_LOADER_CYCLE_COUNT_EN
    localparam int          CC_EN  = 1;
`else
    localparam int          CC_EN  = 0;
`endif
    localparam int K_WRITE = 0, K_START = 1, K_FINISH = 2;

    typedef struct {
        int          kind;
        int          cyc;
        logic [31:0] a;
        logic [31:0] d;
    } ev_t;

    logic            clk = 0;
    logic            i_reset = 1, i_load_begin = 0, i_load_valid = 0, i_load_last = 0;
    logic [31:0]     i_load_data = 0, i_pc = 0;
    logic            o_load_ready, o_mem_we, o_core_reset, o_start, o_busy, o_done, o_error;
    logic [3:0]      o_mem_byte_en;
    logic [MEMB-1:0] o_mem_address;
    logic [31:0]     o_mem_data, o_program_address, o_cycle_count;

    int   cyc = 0, vectors = 0, miscompares = 0, n_we = 0;
    bit   fin_prev = 0;
    ev_t  exp_q[$];
    logic [31:0] prog[$];

    bram_program_loader #(
        .DATA_WIDTH(32), .ADDRESS_BITS(32), .MEM_ADDRESS_BITS(MEMB),
        .PROGRAM_ADDRESS(PADDR), .HALT_PC(32'hA8), .MAX_CYCLES(MAXC)
    ) dut (
        .i_clock(clk), .i_reset(i_reset), .i_load_begin(i_load_begin),
        .i_load_valid(i_load_valid), .o_load_ready(o_load_ready),
        .i_load_data(i_load_data), .i_load_last(i_load_last),
        .o_mem_we(o_mem_we), .o_mem_byte_en(o_mem_byte_en),
        .o_mem_address(o_mem_address), .o_mem_data(o_mem_data),
        .o_core_reset(o_core_reset), .o_start(o_start),
        .o_program_address(o_program_address), .i_pc(i_pc),
        .o_busy(o_busy), .o_done(o_done), .o_error(o_error),
        .o_cycle_count(o_cycle_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic ev_t mk_ev(input int kind, input int c, input logic [31:0] a, input logic [31:0] d);
        ev_t e;
        e.kind = kind; e.cyc = c; e.a = a; e.d = d;
        return e;
    endfunction

    task automatic sb_pop(input int kind, input logic [31:0] a, input logic [31:0] d);
        ev_t e;
        if (exp_q.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL sb_unexpected: got event kind %0d a=%0h d=%0h, expected none", kind, a, d);
            return;
        end
        e = exp_q.pop_front();
        check("sb_kind", kind, e.kind);
        check("sb_cycle", cyc, e.cyc);
        check("sb_a", a, e.a);
        check("sb_d", d, e.d);
    endtask

    // Monitor: compare every DUT-presented event against the queue head.
    always @(negedge clk) begin
        if (!i_reset) begin
            if (o_mem_we) begin
                n_we++;
                check("byte_en", o_mem_byte_en, 4'hF);
                sb_pop(K_WRITE, 32'(o_mem_address), o_mem_data);
            end
            if (o_start)
                sb_pop(K_START, o_program_address, {31'b0, o_core_reset});
            if ((o_done || o_error) && !fin_prev)
                sb_pop(K_FINISH, {28'b0, o_done, o_error, o_core_reset, o_busy}, o_cycle_count);
        end
        fin_prev = o_done || o_error;
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_core_reset"}, o_core_reset, 1'b1);
        check({tag, "_flags"}, {o_load_ready, o_mem_we, o_start, o_busy, o_done, o_error}, 6'b0);
        check({tag, "_mem"}, {o_mem_byte_en, o_mem_address, o_mem_data}, 0);
        check({tag, "_addr_count"}, {o_program_address, o_cycle_count}, 0);
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] v;
        case ($urandom_range(0, 3))
            0:       v = 32'hA4;
            1:       v = 32'hB0;
            default: v = $urandom;
        endcase
        if (v == 32'hA8 || v == 32'hAC) v = 32'h0;
        return v;
    endfunction

    // Stream prog[] into the loader. Model: word i lands at address i one
    // cycle after acceptance; last word -> start two cycles after acceptance;
    // the DEPTH-th word without last -> error finish, core never started.
    task automatic run_load(input bit with_last);
        int i, guard;
        bit stop;
        i_load_begin = 1; tick(); i_load_begin = 0;
        @(negedge clk);
        check("begin_ready", o_load_ready, 1'b1);
        check("begin_busy", o_busy, 1'b1);
        check("begin_core_reset", o_core_reset, 1'b1);
        check("begin_status_clear", {o_done, o_error}, 2'b0);
        tick();
        i = 0; guard = 0; stop = 0;
        while (!stop && i < prog.size() && guard < 400) begin
            i_load_valid = ($urandom_range(0, 3) != 0);
            i_load_data  = prog[i];
            i_load_last  = with_last && (i == prog.size() - 1);
            @(negedge clk);
            if (i_load_valid && o_load_ready) begin
                exp_q.push_back(mk_ev(K_WRITE, cyc + 1, i, prog[i]));
                if (i_load_last) begin
                    exp_q.push_back(mk_ev(K_START, cyc + 2, PADDR, 0));
                    stop = 1;
                end else if (i == DEPTH - 1) begin
                    exp_q.push_back(mk_ev(K_FINISH, cyc + 1, 32'b0110, 0));
                    stop = 1;
                end
                i++;
            end
            tick();
            guard++;
        end
        i_load_valid = 0; i_load_last = 0;
        check("load_within_budget", guard < 400, 1'b1);
    endtask

    // Wait for start, then drive PC: halt value hv at h cycles after START,
    // otherwise non-halting PCs (including the near misses 0xA4 / 0xB0).
    task automatic run_core(input int h, input logic [31:0] hv, input bit halts);
        int s;
        bit seen, fin;
        seen = 0;
        for (int k = 0; k < 8 && !seen; k++) begin
            @(negedge clk);
            if (o_start) seen = 1;
        end
        check("start_seen", seen, 1'b1);
        if (!seen) return;
        s = cyc;
        if (halts) exp_q.push_back(mk_ev(K_FINISH, s + h + 1, 32'b1000, (CC_EN != 0) ? h : 0));
        else       exp_q.push_back(mk_ev(K_FINISH, s + MAXC + 1, 32'b0100, MAXC));
        fin = 0;
        for (int k = 1; k <= MAXC + 5 && !fin; k++) begin
            tick();
            i_pc = (halts && k == h) ? hv : rand_pc();
            @(negedge clk);
            fin = o_done || o_error;
        end
        check("run_finished", fin, 1'b1);
        tick();
        i_pc = 0;
    endtask

    initial begin
        int w0, n;
        repeat (2) tick();
        @(negedge clk);
        check_reset_state("por");
        tick(); i_reset = 0;

        // Idle: load_valid without load_begin must produce nothing.
        i_load_valid = 1; i_load_data = 32'hDEAD_BEEF;
        w0 = n_we;
        repeat (8) tick();
        @(negedge clk);
        check("idle_no_writes", n_we - w0, 0);
        check("idle_ready_low", o_load_ready, 1'b0);
        tick(); i_load_valid = 0;

        // Directed program, halt at 0xA8 twenty cycles after START.
        prog = '{32'h00000013, 32'h00100093, 32'h00200113, 32'h00300193};
        run_load(1);
        run_core(20, 32'hA8, 1);

        // Second halt address, re-entered from DONE.
        prog = '{32'h00000013, 32'h12345678};
        run_load(1);
        run_core(7, 32'hAC, 1);

        // Overflow: DEPTH+1 words with no last.
        prog = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55};
        run_load(0);
        repeat (6) begin
            @(negedge clk);
            check("overflow_no_start", o_start, 1'b0);
            tick();
        end

`ifdef BRAM_LOADER_CYCLE_COUNT_EN
        // Timeout: PC never halts.
        prog = '{32'hCAFE_0001};
        run_load(1);
        run_core(0, 32'h0, 0);
`endif

        // Randomized programs.
        for (int t = 0; t < 8; t++) begin
            n = $urandom_range(1, DEPTH + 1);
            prog.delete();
            for (int j = 0; j < n; j++) prog.push_back($urandom);
            if (n > DEPTH) begin
                run_load(0);
                repeat (3) tick();
            end else begin
                run_load(1);
                run_core($urandom_range(1, 40), ($urandom_range(0, 1) != 0) ? 32'hAC : 32'hA8, 1);
            end
        end

        // Reset in the middle of LOAD.
        prog = '{32'hAAAA_0000, 32'hBBBB_1111};
        run_load(0);
        repeat (3) tick();
        i_load_valid = 1; i_load_data = 32'h5555_5555; i_reset = 1;
        tick();
        @(negedge clk);
        check_reset_state("midload");
        tick(); i_reset = 0;
        w0 = n_we;
        repeat (8) tick();
        @(negedge clk);
        check("post_reset_no_writes", n_we - w0, 0);
        check("post_reset_ready_low", o_load_ready, 1'b0);
        tick(); i_load_valid = 0;

        repeat (4) tick();
        check("sb_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
